// File: rtl/i2c_slave_tx_seq.sv
// rtl/i2c_slave_tx_seq.sv - I2C slave read-path transmit sequencer; I2C_SLAVE_TX_CLK_STRETCH_EN enables clock stretching on TX buffer empty
// Drives load/shift of an MSB-first, all-ones-reset shift register and gates SDA per bit.
module i2c_slave_tx_seq #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic                 scl_rise,
    input  logic                 scl_fall,
    input  logic                 start_detect,
    input  logic                 stop_detect,
    input  logic                 sda_in,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] sr_data,
    output logic                 sr_load,
    output logic                 sr_shift,
    output logic                 sda_drive_en,
    output logic                 scl_hold,
    output logic                 master_ack,
    output logic                 master_nack,
    output logic                 underrun,
    output logic                 busy
);
    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRIVE,
        ACK_WAIT,
        ACK_HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             ack_ok;
    logic             abort;
    logic             fetch_go;
    logic             last_bit;
    logic             starved;

    // A bus START/STOP outranks every other event and suppresses all side effects
    assign abort    = (start_detect | stop_detect) && (state != IDLE);
    assign last_bit = (bit_cnt == LAST_BIT);
    assign starved  = (state == FETCH) && !tx_valid && !abort;

`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
    assign fetch_go = tx_valid;
`else
    // Without stretching, an empty buffer still loads: the master reads all ones
    assign fetch_go = 1'b1;
`endif

    assign tx_ready = (state == FETCH) && tx_valid && !abort;
    assign sr_load  = (state == FETCH) && fetch_go && !abort;
    assign sr_data  = tx_valid ? tx_data : '1;
    assign sr_shift = (state == DRIVE) && scl_fall && !last_bit && !abort;

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (tx_start) state_nxt = FETCH;
                FETCH:    if (fetch_go) state_nxt = DRIVE;
                DRIVE:    if (scl_fall && last_bit) state_nxt = ACK_WAIT;
                ACK_WAIT: if (scl_rise) state_nxt = ACK_HOLD;
                ACK_HOLD: if (scl_fall) state_nxt = ack_ok ? FETCH : IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            ack_ok       <= 1'b0;
            sda_drive_en <= 1'b0;
            scl_hold     <= 1'b0;
            master_ack   <= 1'b0;
            master_nack  <= 1'b0;
            underrun     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt != IDLE);
            // Drive enable rises together with the freshly loaded MSB
            sda_drive_en <= (state_nxt == DRIVE);
            master_ack   <= 1'b0;
            master_nack  <= 1'b0;

            if (sr_load) begin
                bit_cnt <= '0;
            end else if (sr_shift) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if ((state == ACK_WAIT) && scl_rise && !abort) begin
                ack_ok      <= !sda_in;
                master_ack  <= !sda_in;
                master_nack <= sda_in;
            end

`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
            scl_hold <= starved;
            underrun <= 1'b0;
`else
            scl_hold <= 1'b0;
            underrun <= starved;
`endif
        end
    end
endmodule

// File: tb/tb_i2c_slave_tx_seq.sv
// tb/tb_i2c_slave_tx_seq.sv - self-checking bench for i2c_slave_tx_seq (default build or I2C_SLAVE_TX_CLK_STRETCH_EN)
module tb_i2c_slave_tx_seq;
    logic       clk;
    logic       rst;
    logic       tx_start;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_detect;
    logic       stop_detect;
    logic       sda_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] sr_data;
    logic       sr_load;
    logic       sr_shift;
    logic       sda_drive_en;
    logic       scl_hold;
    logic       master_ack;
    logic       master_nack;
    logic       underrun;
    logic       busy;

    i2c_slave_tx_seq #(.DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_detect(start_detect), .stop_detect(stop_detect), .sda_in(sda_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .sr_data(sr_data),
        .sr_load(sr_load), .sr_shift(sr_shift), .sda_drive_en(sda_drive_en), .scl_hold(scl_hold),
        .master_ack(master_ack), .master_nack(master_nack), .underrun(underrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // External shift register: MSB-first, resets to all ones
    logic [7:0] m_sr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_sr <= 8'hFF;
        else if (sr_load) m_sr <= sr_data;
        else if (sr_shift) m_sr <= {m_sr[6:0], 1'b1};
    end

    // Load scoreboard: expected bytes written by stimulus, consumed on sr_load
    logic [7:0] exp_loads [0:63];
    int wr_idx = 0;
    int rd_idx = 0;

    int n_load = 0, n_shift = 0, n_ready = 0, n_ack = 0, n_nack = 0;
    int n_under = 0, n_hold = 0, n_bits = 0;
    logic [31:0] sda_hist = '0;

    always @(negedge clk) begin
        if (sr_load) begin
            n_load++;
            if (rd_idx >= wr_idx) begin
                chk("load_unexpected", 32'd1, 32'd0);
            end else begin
                chk("load_data", 32'(sr_data), 32'(exp_loads[rd_idx]));
                rd_idx++;
            end
        end
        if (sr_shift) n_shift++;
        if (tx_ready) n_ready++;
        if (master_ack) n_ack++;
        if (master_nack) n_nack++;
        if (underrun) n_under++;
        if (scl_hold) n_hold++;
        if (scl_rise && sda_drive_en) begin
            sda_hist = {sda_hist[30:0], m_sr[7]};
            n_bits++;
        end
    end

    int b_load, b_shift, b_ready, b_ack, b_nack, b_under, b_bits;

    task automatic mark();
        b_load = n_load; b_shift = n_shift; b_ready = n_ready; b_ack = n_ack;
        b_nack = n_nack; b_under = n_under; b_bits = n_bits;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d);
        exp_loads[wr_idx] = d;
        wr_idx++;
    endtask

    task automatic data_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            scl_rise = 1'b1; step(); scl_rise = 1'b0; step();
            scl_fall = 1'b1; step(); scl_fall = 1'b0; step();
        end
    endtask

    // Eight data bits then the ACK slot; ends in the cycle after the ACK scl_fall
    task automatic do_bits(input logic nack);
        data_pulses(7);
        scl_rise = 1'b1; step(); scl_rise = 1'b0; step();
        scl_fall = 1'b1; step(); scl_fall = 1'b0;
        chk("sda_release_after_last_fall", 32'(sda_drive_en), 32'd0);
        step();
        sda_in = nack; scl_rise = 1'b1; step();
        scl_rise = 1'b0; sda_in = 1'b1;
        chk("ack_pulse_timing", 32'(master_ack), 32'(!nack));
        chk("nack_pulse_timing", 32'(master_nack), 32'(nack));
        step();
        scl_fall = 1'b1; step(); scl_fall = 1'b0;
    endtask

    task automatic run_byte(input logic [7:0] d, input logic [7:0] nd, input bit start, input bit nack);
        mark();
        tx_data = d; tx_valid = 1'b1;
        push_exp(d);
        if (start) begin
            tx_start = 1'b1; step(); tx_start = 1'b0;
        end
        step();
        tx_data = nd;
        do_bits(nack);
        chk("byte_loads", 32'(n_load - b_load), 32'd1);
        chk("byte_shifts", 32'(n_shift - b_shift), 32'd7);
        chk("byte_ready", 32'(n_ready - b_ready), 32'd1);
        chk("byte_acks", 32'(n_ack - b_ack), nack ? 32'd0 : 32'd1);
        chk("byte_nacks", 32'(n_nack - b_nack), nack ? 32'd1 : 32'd0);
        chk("byte_underrun", 32'(n_under - b_under), 32'd0);
        chk("byte_bits", 32'(n_bits - b_bits), 32'd8);
        chk("byte_sda", 32'(sda_hist[7:0]), 32'(d));
        chk("byte_busy_after", 32'(busy), nack ? 32'd0 : 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         start;
        bit         nack;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h81, 1'b1, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 1'b1};

        rst = 1'b1; tx_start = 1'b0; scl_rise = 1'b0; scl_fall = 1'b0;
        start_detect = 1'b0; stop_detect = 1'b0; sda_in = 1'b1;
        tx_data = 8'h00; tx_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sda_drive_en", 32'(sda_drive_en), 32'd0);
        chk("reset_scl_hold", 32'(scl_hold), 32'd0);
        chk("reset_master_ack", 32'(master_ack), 32'd0);
        chk("reset_master_nack", 32'(master_nack), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_byte(vecs[i].data, (i < 5) ? vecs[i+1].data : 8'h00, vecs[i].start, vecs[i].nack);
        end

`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
        // Clock stretch: five starved FETCH cycles, then 0x3C
        begin
            int h0;
            mark();
            h0 = n_hold;
            tx_valid = 1'b0; tx_start = 1'b1; step(); tx_start = 1'b0;
            for (int i = 0; i < 5; i++) begin
                chk("stretch_no_load", 32'(sr_load), 32'd0);
                step();
            end
            tx_valid = 1'b1; tx_data = 8'h3C; push_exp(8'h3C);
            chk("stretch_load", 32'(sr_load), 32'd1);
            chk("stretch_hold_at_load", 32'(scl_hold), 32'd1);
            step();
            chk("stretch_hold_clear", 32'(scl_hold), 32'd0);
            chk("stretch_hold_cycles", 32'(n_hold - h0), 32'd5);
            do_bits(1'b1);
            chk("stretch_sda", 32'(sda_hist[7:0]), 32'h3C);
            chk("stretch_underrun", 32'(n_under - b_under), 32'd0);
        end
`else
        // Underrun: empty buffer at FETCH sends all ones
        mark();
        tx_valid = 1'b0; tx_start = 1'b1; step(); tx_start = 1'b0;
        push_exp(8'hFF);
        chk("underrun_load", 32'(sr_load), 32'd1);
        chk("underrun_sr_data", 32'(sr_data), 32'hFF);
        chk("underrun_ready", 32'(tx_ready), 32'd0);
        step();
        chk("underrun_pulse", 32'(underrun), 32'd1);
        chk("underrun_scl_hold", 32'(scl_hold), 32'd0);
        do_bits(1'b1);
        chk("underrun_count", 32'(n_under - b_under), 32'd1);
        chk("underrun_sda", 32'(sda_hist[7:0]), 32'hFF);
        chk("underrun_ready_count", 32'(n_ready - b_ready), 32'd0);
`endif

        // Abort: stop_detect coincident with the 5th data scl_fall
        mark();
        tx_valid = 1'b1; tx_data = 8'h96; push_exp(8'h96);
        tx_start = 1'b1; step(); tx_start = 1'b0;
        step();
        data_pulses(4);
        scl_rise = 1'b1; step(); scl_rise = 1'b0; step();
        scl_fall = 1'b1; stop_detect = 1'b1;
        chk("abort_no_shift", 32'(sr_shift), 32'd0);
        step();
        scl_fall = 1'b0; stop_detect = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sda_drive_en", 32'(sda_drive_en), 32'd0);
        sda_in = 1'b0;
        data_pulses(2);
        sda_in = 1'b1;
        chk("abort_shifts", 32'(n_shift - b_shift), 32'd4);
        chk("abort_acks", 32'(n_ack - b_ack), 32'd0);
        chk("abort_nacks", 32'(n_nack - b_nack), 32'd0);
        chk("abort_idle_ready", 32'(n_ready - b_ready), 32'd1);

        // Reset asserted while bit 3 is on the bus
        tx_data = 8'hC3; push_exp(8'hC3);
        tx_start = 1'b1; step(); tx_start = 1'b0;
        step();
        tx_valid = 1'b0;
        data_pulses(3);
        rst = 1'b1;
        #1;
        chk("rst_sda_drive_en", 32'(sda_drive_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_scl_hold", 32'(scl_hold), 32'd0);
        chk("rst_sr_load", 32'(sr_load), 32'd0);
        chk("rst_sr_shift", 32'(sr_shift), 32'd0);
        chk("rst_ack", 32'(master_ack | master_nack | underrun), 32'd0);
        #2;
        rst = 1'b0;
        step();
        run_byte(8'h5A, 8'h00, 1'b1, 1'b1);
        chk("scoreboard_drained", 32'(wr_idx - rd_idx), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
